// File: rtl/adc_scan_averager.sv
// adc_scan_averager: per-channel block averager with threshold alarms and a
// registered, channel-selectable readout.
// Optional min/max tracking of completed averages: define ADC_SCAN_MINMAX_EN.
module adc_scan_averager #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned OUT_W    = 8,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              SAMPLE_VALID,
    input  logic [CH_W-1:0]   SAMPLE_CH,
    input  logic [DATA_W-1:0] SAMPLE_DATA,
    input  logic [CH_W-1:0]   SEL,
    input  logic [DATA_W-1:0] THRESH,
`ifdef ADC_SCAN_MINMAX_EN
    input  logic              CLEAR_MINMAX,
    output logic [DATA_W-1:0] MIN_OUT,
    output logic [DATA_W-1:0] MAX_OUT,
`endif
    output logic [DATA_W-1:0] AVG_OUT,
    output logic              AVG_VALID,
    output logic [OUT_W-1:0]  DISPLAY,
    output logic              UPDATE,
    output logic [CH_W-1:0]   UPDATE_CH,
    output logic [NUM_CH-1:0] ALARM
);

    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    // With AVG_LOG2 = 0 the counter is a constant-zero bit and every sample completes.
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [DATA_W-1:0] avg_q [NUM_CH];
    logic [DATA_W-1:0] avg_d [NUM_CH];
    logic [NUM_CH-1:0] vld_q, vld_d;
    logic [NUM_CH-1:0] alarm_q, alarm_d;
    logic              update_q, update_d;
    logic [CH_W-1:0]   update_ch_q, update_ch_d;
    logic [DATA_W-1:0] avg_out_q, avg_out_d;
    logic              avg_valid_q, avg_valid_d;

    logic              smp_ok, sel_ok, done;
    logic [ACC_W-1:0]  sum;
    logic [DATA_W-1:0] avg_new;

    // Decode the incoming sample: range check, running sum and block completion.
    always_comb begin
        smp_ok  = SAMPLE_VALID && ({1'b0, SAMPLE_CH} < NUM_CH_L);
        sel_ok  = {1'b0, SEL} < NUM_CH_L;
        sum     = '0;
        avg_new = '0;
        done    = 1'b0;
        if (smp_ok) begin
            sum     = acc_q[SAMPLE_CH] + ACC_W'(SAMPLE_DATA);
            avg_new = DATA_W'(sum >> AVG_LOG2);
            done    = (cnt_q[SAMPLE_CH] == CNT_LAST);
        end
    end

    // Next state of per-channel accumulators, averages, alarms and the readout.
    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        vld_d       = vld_q;
        alarm_d     = alarm_q;
        update_d    = 1'b0;
        update_ch_d = update_ch_q;
        if (smp_ok) begin
            if (done) begin
                acc_d[SAMPLE_CH]   = '0;
                cnt_d[SAMPLE_CH]   = '0;
                avg_d[SAMPLE_CH]   = avg_new;
                vld_d[SAMPLE_CH]   = 1'b1;
                alarm_d[SAMPLE_CH] = avg_new > THRESH;
                update_d           = 1'b1;
                update_ch_d        = SAMPLE_CH;
            end else begin
                acc_d[SAMPLE_CH] = sum;
                cnt_d[SAMPLE_CH] = cnt_q[SAMPLE_CH] + CNT_W'(1);
            end
        end
        // Readout uses the pre-update average, so a same-cycle completion shows next cycle.
        avg_out_d   = sel_ok ? avg_q[SEL] : '0;
        avg_valid_d = sel_ok && vld_q[SEL];
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
                avg_q[i] <= '0;
            end
            vld_q       <= '0;
            alarm_q     <= '0;
            update_q    <= 1'b0;
            update_ch_q <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            vld_q       <= vld_d;
            alarm_q     <= alarm_d;
            update_q    <= update_d;
            update_ch_q <= update_ch_d;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign AVG_OUT   = avg_out_q;
    assign AVG_VALID = avg_valid_q;
    assign DISPLAY   = avg_out_q[DATA_W-1 -: OUT_W];
    assign UPDATE    = update_q;
    assign UPDATE_CH = update_ch_q;
    assign ALARM     = alarm_q;

`ifdef ADC_SCAN_MINMAX_EN
    logic [DATA_W-1:0] min_q [NUM_CH];
    logic [DATA_W-1:0] min_d [NUM_CH];
    logic [DATA_W-1:0] max_q [NUM_CH];
    logic [DATA_W-1:0] max_d [NUM_CH];
    logic [NUM_CH-1:0] mm_vld_q, mm_vld_d;
    logic [DATA_W-1:0] min_out_q, min_out_d, max_out_q, max_out_d;

    // Track extremes of completed averages; clear wins over a same-cycle completion.
    always_comb begin
        min_d    = min_q;
        max_d    = max_q;
        mm_vld_d = mm_vld_q;
        if (CLEAR_MINMAX) begin
            mm_vld_d = '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                min_d[i] = '0;
                max_d[i] = '0;
            end
        end else if (smp_ok && done) begin
            if (!mm_vld_q[SAMPLE_CH]) begin
                min_d[SAMPLE_CH]    = avg_new;
                max_d[SAMPLE_CH]    = avg_new;
                mm_vld_d[SAMPLE_CH] = 1'b1;
            end else begin
                if (avg_new < min_q[SAMPLE_CH]) min_d[SAMPLE_CH] = avg_new;
                if (avg_new > max_q[SAMPLE_CH]) max_d[SAMPLE_CH] = avg_new;
            end
        end
        min_out_d = sel_ok ? min_q[SEL] : '0;
        max_out_d = sel_ok ? max_q[SEL] : '0;
    end

    // Min/max registers with synchronous reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                min_q[i] <= '0;
                max_q[i] <= '0;
            end
            mm_vld_q  <= '0;
            min_out_q <= '0;
            max_out_q <= '0;
        end else begin
            min_q     <= min_d;
            max_q     <= max_d;
            mm_vld_q  <= mm_vld_d;
            min_out_q <= min_out_d;
            max_out_q <= max_out_d;
        end
    end

    assign MIN_OUT = min_out_q;
    assign MAX_OUT = max_out_q;
`endif

endmodule

// File: doc/adc_scan_averager.md
Name: adc_scan_averager

Overview:
- Parametrised multi-channel post-processor placed between the serial ADC controller and the board display/logic.
- Accepts one tagged sample per accepted handshake and keeps a per-channel block average of 2^AVG_LOG2 samples.
- Compares each completed average against a threshold to drive a per-channel alarm.
- Presents a registered, selectable readout that replaces the flat switch-to-LED mux.

Parameters:
- NUM_CH, 8, number of channels tracked (1..16).
- DATA_W, 12, sample width in bits.
- AVG_LOG2, 2, log2 of samples per average block (0..6; 0 = pass-through).
- OUT_W, 8, display width in bits (OUT_W <= DATA_W).
- CH_W is derived as max(1, clog2(NUM_CH)).

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  synchronous active-high reset, sampled on the CLOCK rising edge.
- SAMPLE_VALID  in  1  sample strobe from the ADC controller, one cycle per sample.
- SAMPLE_CH  in  CH_W  channel tag of the sample.
- SAMPLE_DATA  in  DATA_W  unsigned sample value.
- SEL  in  CH_W  readout channel select.
- THRESH  in  DATA_W  alarm threshold, unsigned.
- AVG_OUT  out  DATA_W  registered average of channel SEL.
- AVG_VALID  out  1  channel SEL has completed at least one block since reset.
- DISPLAY  out  OUT_W  AVG_OUT[DATA_W-1 -: OUT_W].
- UPDATE  out  1  one-cycle pulse when any channel completes a block.
- UPDATE_CH  out  CH_W  channel that completed; holds its value between pulses.
- ALARM  out  NUM_CH  per-channel flag: last completed average > THRESH.

Behaviour:
- Reset: all accumulators, counters, stored averages, valid flags, ALARM, AVG_OUT, AVG_VALID, UPDATE and UPDATE_CH go to 0 in the cycle after RESET is high.
  - RESET outranks every simultaneous input.
  - Reset mid-block discards the partial sums.
- Per-channel state:
  - acc[ch] is DATA_W+AVG_LOG2 bits.
  - cnt[ch] is AVG_LOG2 bits (absent when AVG_LOG2 = 0).
  - avg[ch] is DATA_W bits.
  - vld[ch] is 1 bit.
- Sample acceptance, per clock edge with SAMPLE_VALID = 1 and SAMPLE_CH < NUM_CH (ch = SAMPLE_CH):
  - If cnt[ch] != 2^AVG_LOG2-1: acc[ch] += SAMPLE_DATA and cnt[ch] += 1.
  - If cnt[ch] == 2^AVG_LOG2-1 (block complete):
    - avg[ch] <= (acc[ch] + SAMPLE_DATA) >> AVG_LOG2, truncated (floor).
    - acc[ch] <= 0, cnt[ch] <= 0, vld[ch] <= 1.
    - ALARM[ch] <= ((acc[ch]+SAMPLE_DATA)>>AVG_LOG2) > THRESH.
    - UPDATE <= 1, UPDATE_CH <= ch.
  - UPDATE is 0 in every cycle that did not follow a completion.
  - Samples with SAMPLE_CH >= NUM_CH are ignored: no state change and no UPDATE.
- No overflow is possible: the accumulator holds 2^AVG_LOG2 full-scale samples exactly.
- Per-channel counters and accumulators are independent, so arbitrary interleaving of channels is legal.
- Back-to-back SAMPLE_VALID is supported every cycle; there is no backpressure.
- Readout: every cycle, AVG_OUT <= avg[SEL] and AVG_VALID <= vld[SEL].
  - SEL >= NUM_CH gives AVG_OUT = 0 and AVG_VALID = 0.
- Latency:
  - SEL change to AVG_OUT: 1 cycle.
  - Completing sample to avg/ALARM/UPDATE: 1 cycle.
  - Completing sample to AVG_OUT: 2 cycles.
- A completion for channel SEL in the same cycle as a readout: the readout shows the old average; the new value appears one cycle later.
- THRESH changes affect ALARM only at that channel's next completion. ALARM is not re-evaluated continuously.

Optional Feature:
- Macro: ADC_SCAN_MINMAX_EN.
- When defined:
  - Adds ports CLEAR_MINMAX in 1, MIN_OUT out DATA_W and MAX_OUT out DATA_W.
  - Per-channel min[ch]/max[ch] track completed averages.
  - The first completion after reset or clear loads both min and max.
  - MIN_OUT/MAX_OUT are registered from channel SEL with the same 1-cycle latency as AVG_OUT.
  - CLEAR_MINMAX = 1 marks all channels empty; MIN_OUT/MAX_OUT read 0 until the next completion.
  - A completion in the same cycle as CLEAR_MINMAX is discarded for min/max tracking.
  - Reset clears min/max as above.
- When undefined: none of these ports or registers exist; all other behaviour is identical.

Test Plan:
Defaults unless stated: NUM_CH=8, DATA_W=12, AVG_LOG2=2, OUT_W=8.
- Ch3 samples 100, 200, 300, 400 on consecutive cycles, SEL=3:
  - UPDATE pulses for one cycle, 1 cycle after the 4th sample, with UPDATE_CH=3.
  - AVG_OUT=250, AVG_VALID=1 and DISPLAY=15, 2 cycles after the 4th sample.
  - No UPDATE after samples 1-3.
- Interleaved samples:
  - Ch0 gets 10, 20, 30, 40; ch1 gets 1000×4, alternating every cycle.
  - Result: avg0=25, avg1=1000.
  - Toggling SEL 0→1 changes AVG_OUT 25→1000 after 1 cycle.
- Ch7 gets 4095×4 → AVG_OUT=4095 and DISPLAY=255, with no wrap. Then ch7 gets 1, 1, 1, 2 → AVG_OUT=1 (floor of 5/4).
- THRESH=2000:
  - Ch2 block averaging 2001 → ALARM=8'b0000_0100.
  - Next ch2 block averaging exactly 2000 → ALARM=0.
  - THRESH changed to 0 with no new completion → ALARM stays 0.
- Ch5 gets 2 samples of 4000, then RESET for 1 cycle, then 4 samples of 8:
  - AVG_OUT=8 (partial sums discarded).
  - AVG_VALID=0 between reset and completion.
  - RESET asserted together with a completing sample → no UPDATE and all outputs 0.
- NUM_CH=6: SAMPLE_CH=7 ×4 → no UPDATE and no state change. SEL=7 → AVG_OUT=0, AVG_VALID=0.
  - Build with ADC_SCAN_MINMAX_EN: ch0 blocks averaging 50, 300, 20 → MIN_OUT=20, MAX_OUT=300.
  - Then CLEAR_MINMAX → MIN_OUT=0, MAX_OUT=0.
